// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types for the pipeline hazard controller
// Purpose: FSM state encoding, pipeline-register indices and the per-register
//          enable/flush control pair.
// Ports:   none (package)
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    REDIRECT = 2'd2
  } pc_state_t;

  // Pipeline register indices (register sits between the named stages)
  localparam int IDX_FD   = 0;
  localparam int IDX_DE   = 1;
  localparam int IDX_EM   = 2;
  localparam int NUM_REGS = 3;

  typedef struct packed {
    logic en;
    logic flush;
  } pipe_ctl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_cnt.sv
// rtl/pipe_hazard_ctrl_sat_cnt.sv - saturating event counter with synchronous clear
// Purpose: counts inc pulses, sticks at all-ones; clr wins over inc.
// Ports:   clk, n_rst (async active-low), clr, inc, q[CNT_W-1:0]
module sat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {CNT_W{1'b1}})) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/redirect control for the 6-stage core
// Purpose: drives en/flush of the F_D, D_E, E_M1 registers and PC enable/redirect
//          for load-use stalls, MDU waits and mispredict refill; perf counters.
// Ports:   clk, n_rst; D-stage sources d_rs1/d_rs2/d_use_rs1/d_use_rs2;
//          E/M1 dests e_rd/m1_rd, e_load/m1_load; e_mispredict, e_mdu_start,
//          mdu_done, cnt_clr; outputs pc_en, pc_redirect, en_/flush_ FD/DE/EM,
//          state_o, stall_cnt, redirect_cnt.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int FETCH_LAT = 1,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [REG_AW-1:0] d_rs1,
  input  logic [REG_AW-1:0] d_rs2,
  input  logic              d_use_rs1,
  input  logic              d_use_rs2,
  input  logic [REG_AW-1:0] e_rd,
  input  logic [REG_AW-1:0] m1_rd,
  input  logic              e_load,
  input  logic              m1_load,
  input  logic              e_mispredict,
  input  logic              e_mdu_start,
  input  logic              mdu_done,
  input  logic              cnt_clr,
  output logic              pc_en,
  output logic              pc_redirect,
  output logic              en_FD,
  output logic              flush_FD,
  output logic              en_DE,
  output logic              flush_DE,
  output logic              en_EM,
  output logic              flush_EM,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  redirect_cnt
);

  localparam int RC_W = (FETCH_LAT < 2) ? 1 : $clog2(FETCH_LAT + 1);

  pc_state_t state, state_nxt;
  logic [RC_W-1:0] cnt, cnt_nxt;
  pipe_ctl_t ctl [NUM_REGS];
  logic lu;

  // Load data only forwards from M2/W, so a load still in E or M1 blocks D.
  always_comb begin
    lu = (d_use_rs1 && (d_rs1 != '0) &&
          ((e_load && (d_rs1 == e_rd)) || (m1_load && (d_rs1 == m1_rd)))) ||
         (d_use_rs2 && (d_rs2 != '0) &&
          ((e_load && (d_rs2 == e_rd)) || (m1_load && (d_rs2 == m1_rd))));
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      ctl[i].en    = 1'b1;
      ctl[i].flush = 1'b0;
    end
    pc_en       = 1'b1;
    pc_redirect = 1'b0;
    state_nxt   = state;
    cnt_nxt     = cnt;

    case (state)
      RUN: begin
        if (e_mispredict) begin
          pc_redirect          = 1'b1;
          ctl[IDX_FD].flush    = 1'b1;
          ctl[IDX_DE].flush    = 1'b1;
          cnt_nxt              = RC_W'(FETCH_LAT);
          state_nxt            = REDIRECT;
        end else if (e_mdu_start && !mdu_done) begin
          // Hold F/D/E, drain a bubble into M1 while the MDU works.
          pc_en             = 1'b0;
          ctl[IDX_FD].en    = 1'b0;
          ctl[IDX_DE].en    = 1'b0;
          ctl[IDX_EM].flush = 1'b1;
          state_nxt         = MDU_WAIT;
        end else if (lu) begin
          pc_en             = 1'b0;
          ctl[IDX_FD].en    = 1'b0;
          ctl[IDX_DE].flush = 1'b1;
        end
      end
      MDU_WAIT: begin
        if (!mdu_done) begin
          pc_en             = 1'b0;
          ctl[IDX_FD].en    = 1'b0;
          ctl[IDX_DE].en    = 1'b0;
          ctl[IDX_EM].flush = 1'b1;
        end else begin
          state_nxt = RUN;
        end
      end
      REDIRECT: begin
        // Synchronous imem: the fetch in flight still belongs to the old path.
        ctl[IDX_FD].flush = 1'b1;
        if (e_mispredict) begin
          pc_redirect = 1'b1;
          cnt_nxt     = RC_W'(FETCH_LAT);
        end else begin
          cnt_nxt = cnt - RC_W'(1);
          if (cnt == RC_W'(1)) begin
            state_nxt = RUN;
          end
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  assign en_FD    = ctl[IDX_FD].en;
  assign flush_FD = ctl[IDX_FD].flush;
  assign en_DE    = ctl[IDX_DE].en;
  assign flush_DE = ctl[IDX_DE].flush;
  assign en_EM    = ctl[IDX_EM].en;
  assign flush_EM = ctl[IDX_EM].flush;
  assign state_o  = state;

  sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (cnt_clr),
    .inc   (!pc_en),
    .q     (stall_cnt)
  );

  sat_cnt #(.CNT_W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (cnt_clr),
    .inc   (pc_redirect),
    .q     (redirect_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int AW  = 5;
  localparam int FL  = 1;
  localparam int CW  = 4;
  localparam int SAT = 15;

  logic clk = 1'b0;
  logic n_rst;
  logic [AW-1:0] d_rs1, d_rs2, e_rd, m1_rd;
  logic d_use_rs1, d_use_rs2, e_load, m1_load;
  logic e_mispredict, e_mdu_start, mdu_done, cnt_clr;
  logic pc_en, pc_redirect, en_FD, flush_FD, en_DE, flush_DE, en_EM, flush_EM;
  logic [1:0] state_o;
  logic [CW-1:0] stall_cnt, redirect_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model: abstract pipeline condition rather than FSM encoding.
  bit m_mdu_busy;
  int m_refill_left;
  int m_stall;
  int m_redir;

  pipe_hazard_ctrl #(.REG_AW(AW), .FETCH_LAT(FL), .CNT_W(CW)) dut (
    .clk(clk), .n_rst(n_rst),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
    .e_rd(e_rd), .m1_rd(m1_rd), .e_load(e_load), .m1_load(m1_load),
    .e_mispredict(e_mispredict), .e_mdu_start(e_mdu_start), .mdu_done(mdu_done),
    .cnt_clr(cnt_clr),
    .pc_en(pc_en), .pc_redirect(pc_redirect),
    .en_FD(en_FD), .flush_FD(flush_FD), .en_DE(en_DE), .flush_DE(flush_DE),
    .en_EM(en_EM), .flush_EM(flush_EM),
    .state_o(state_o), .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit reads_pending_load(logic use_r, logic [AW-1:0] rs);
    return use_r && (rs != 0) &&
           ((e_load && rs == e_rd) || (m1_load && rs == m1_rd));
  endfunction

  // {pc_en, pc_redirect, en_FD, flush_FD, en_DE, flush_DE, en_EM, flush_EM}
  function automatic logic [7:0] model_out();
    logic [7:0] free_run   = 8'b1010_1010;
    logic [7:0] mdu_hold   = 8'b0000_0011;
    logic [7:0] lu_bubble  = 8'b0000_1110;
    logic [7:0] redirect   = 8'b1111_1110;
    logic [7:0] refill     = 8'b1011_1010;
    logic [7:0] refill_re  = 8'b1111_1010;
    bit hazard = reads_pending_load(d_use_rs1, d_rs1) || reads_pending_load(d_use_rs2, d_rs2);
    if (m_mdu_busy) return mdu_done ? free_run : mdu_hold;
    if (m_refill_left > 0) return e_mispredict ? refill_re : refill;
    if (e_mispredict) return redirect;
    if (e_mdu_start && !mdu_done) return mdu_hold;
    if (hazard) return lu_bubble;
    return free_run;
  endfunction

  function automatic logic [1:0] model_state();
    if (m_mdu_busy) return 2'd1;
    if (m_refill_left > 0) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [7:0] dut_out();
    return {pc_en, pc_redirect, en_FD, flush_FD, en_DE, flush_DE, en_EM, flush_EM};
  endfunction

  task automatic model_reset();
    m_mdu_busy = 0; m_refill_left = 0; m_stall = 0; m_redir = 0;
  endtask

  task automatic idle();
    d_rs1 = '0; d_rs2 = '0; e_rd = '0; m1_rd = '0;
    d_use_rs1 = 0; d_use_rs2 = 0; e_load = 0; m1_load = 0;
    e_mispredict = 0; e_mdu_start = 0; mdu_done = 0; cnt_clr = 0;
  endtask

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic tick();
    logic [7:0] e;
    e = model_out();
    @(posedge clk);
    #1;
    if (cnt_clr) begin
      m_stall = 0; m_redir = 0;
    end else begin
      if (!e[7] && m_stall < SAT) m_stall++;
      if (e[6] && m_redir < SAT) m_redir++;
    end
    if (m_mdu_busy) begin
      if (mdu_done) m_mdu_busy = 0;
    end else if (m_refill_left > 0) begin
      if (e_mispredict) m_refill_left = FL;
      else m_refill_left--;
    end else if (e_mispredict) begin
      m_refill_left = FL;
    end else if (e_mdu_start && !mdu_done) begin
      m_mdu_busy = 1;
    end
  endtask

  task automatic clear_counters();
    idle(); cnt_clr = 1; tick(); cnt_clr = 0;
  endtask

  task automatic test_reset();
    idle(); model_reset();
    n_rst = 0;
    #12;
    tests++;
    if (state_o !== 2'd0 || stall_cnt !== 0 || redirect_cnt !== 0) begin
      fails++;
      $display("FAIL reset_state: state=%0d stall=%0d redir=%0d want 0/0/0", state_o, stall_cnt, redirect_cnt);
    end
    tests++;
    if (dut_out() !== 8'b1010_1010) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 10101010", dut_out());
    end
    @(negedge clk);
    n_rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    clear_counters();
    e_load = 1; e_rd = 5; d_rs1 = 5; d_use_rs1 = 1;
    #1;
    tests++;
    if ({pc_en, en_FD, flush_DE} !== 3'b001) begin
      fails++;
      $display("FAIL lu_e_cycle: pc_en,en_FD,flush_DE=%b want 001", {pc_en, en_FD, flush_DE});
    end
    tick();
    e_load = 0; m1_load = 1; m1_rd = 5;
    #1;
    tests++;
    if ({pc_en, en_FD, flush_DE} !== 3'b001) begin
      fails++;
      $display("FAIL lu_m1_cycle: pc_en,en_FD,flush_DE=%b want 001", {pc_en, en_FD, flush_DE});
    end
    tick();
    m1_load = 0;
    #1;
    tests++;
    if (dut_out() !== 8'b1010_1010) begin
      fails++;
      $display("FAIL lu_free_cycle: got %b want 10101010", dut_out());
    end
    tick();
    tests++;
    if (stall_cnt !== 4'd2) begin
      fails++;
      $display("FAIL lu_stall_cnt: got %0d want 2", stall_cnt);
    end
    idle();
  endtask

  task automatic test_x0();
    idle();
    e_load = 1; e_rd = 0; d_rs1 = 0; d_use_rs1 = 1;
    #1;
    tests++;
    if (pc_en !== 1'b1 || flush_DE !== 1'b0) begin
      fails++;
      $display("FAIL x0_immune: pc_en=%b flush_DE=%b want 1/0", pc_en, flush_DE);
    end
    e_rd = 7; d_rs2 = 7; d_use_rs2 = 0; d_use_rs1 = 0; d_rs1 = 7;
    #1;
    tests++;
    if (pc_en !== 1'b1 || flush_DE !== 1'b0) begin
      fails++;
      $display("FAIL unused_src: pc_en=%b flush_DE=%b want 1/0", pc_en, flush_DE);
    end
    tick();
    idle();
  endtask

  task automatic test_mdu();
    clear_counters();
    e_mdu_start = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if ({pc_en, en_DE, flush_EM} !== 3'b001) begin
        fails++;
        $display("FAIL mdu_hold_%0d: pc_en,en_DE,flush_EM=%b want 001", i, {pc_en, en_DE, flush_EM});
      end
      tick();
    end
    mdu_done = 1;
    #1;
    tests++;
    if (dut_out() !== 8'b1010_1010) begin
      fails++;
      $display("FAIL mdu_done_cycle: got %b want 10101010", dut_out());
    end
    tick();
    e_mdu_start = 0; mdu_done = 0;
    #1;
    tests++;
    if (state_o !== 2'd0 || stall_cnt !== 4'd4) begin
      fails++;
      $display("FAIL mdu_after: state=%0d stall=%0d want 0/4", state_o, stall_cnt);
    end
    e_mdu_start = 1; mdu_done = 1;
    #1;
    tests++;
    if (pc_en !== 1'b1 || flush_EM !== 1'b0) begin
      fails++;
      $display("FAIL mdu_same_cycle: pc_en=%b flush_EM=%b want 1/0", pc_en, flush_EM);
    end
    tick();
    idle();
    #1;
    tests++;
    if (state_o !== 2'd0 || stall_cnt !== 4'd4) begin
      fails++;
      $display("FAIL mdu_same_after: state=%0d stall=%0d want 0/4", state_o, stall_cnt);
    end
  endtask

  task automatic test_mispredict();
    clear_counters();
    e_mispredict = 1; e_load = 1; e_rd = 9; d_rs1 = 9; d_use_rs1 = 1;
    #1;
    tests++;
    if (dut_out() !== 8'b1111_1110) begin
      fails++;
      $display("FAIL mispredict_lu: got %b want 11111110", dut_out());
    end
    tick();
    idle();
    e_load = 1; e_rd = 4; d_rs1 = 4; d_use_rs1 = 1;
    #1;
    tests++;
    if (dut_out() !== 8'b1011_1010 || state_o !== 2'd2) begin
      fails++;
      $display("FAIL refill_cycle: got %b st=%0d want 10111010 st=2", dut_out(), state_o);
    end
    tick();
    idle();
    #1;
    tests++;
    if (state_o !== 2'd0 || redirect_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
      fails++;
      $display("FAIL redirect_done: st=%0d redir=%0d stall=%0d want 0/1/0", state_o, redirect_cnt, stall_cnt);
    end
  endtask

  task automatic test_mdu_mispredict();
    clear_counters();
    e_mdu_start = 1;
    tick();
    e_mispredict = 1;
    #1;
    tests++;
    if (pc_redirect !== 1'b0 || pc_en !== 1'b0 || flush_FD !== 1'b0) begin
      fails++;
      $display("FAIL mdu_ignores_mp: redirect=%b pc_en=%b flush_FD=%b want 0/0/0", pc_redirect, pc_en, flush_FD);
    end
    tick();
    e_mispredict = 0; mdu_done = 1;
    tick();
    idle();
    #1;
    tests++;
    if (redirect_cnt !== 4'd0 || state_o !== 2'd0) begin
      fails++;
      $display("FAIL mdu_mp_after: redir=%0d st=%0d want 0/0", redirect_cnt, state_o);
    end
  endtask

  task automatic test_counters();
    clear_counters();
    e_load = 1; e_rd = 3; d_rs1 = 3; d_use_rs1 = 1;
    for (int i = 0; i < 20; i++) tick();
    tests++;
    if (stall_cnt !== 4'd15) begin
      fails++;
      $display("FAIL stall_saturate: got %0d want 15", stall_cnt);
    end
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    tests++;
    if (stall_cnt !== 4'd0) begin
      fails++;
      $display("FAIL clr_beats_inc: got %0d want 0", stall_cnt);
    end
    idle();
    tick();
    e_mispredict = 1;
    tick();
    idle();
    tests++;
    if (state_o !== 2'd2 || redirect_cnt !== 4'd1) begin
      fails++;
      $display("FAIL pre_reset_redirect: st=%0d redir=%0d want 2/1", state_o, redirect_cnt);
    end
    n_rst = 0;
    model_reset();
    #1;
    tests++;
    if (state_o !== 2'd0 || stall_cnt !== 0 || redirect_cnt !== 0) begin
      fails++;
      $display("FAIL async_reset_redirect: st=%0d stall=%0d redir=%0d want 0/0/0", state_o, stall_cnt, redirect_cnt);
    end
    @(negedge clk);
    n_rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [7:0] exp_o;
    for (int cyc = 0; cyc < 400; cyc++) begin
      d_rs1 = AW'($urandom_range(0, 3)); d_rs2 = AW'($urandom_range(0, 3));
      e_rd  = AW'($urandom_range(0, 3)); m1_rd = AW'($urandom_range(0, 3));
      d_use_rs1 = 1'($urandom); d_use_rs2 = 1'($urandom);
      e_load = 1'($urandom); m1_load = 1'($urandom);
      e_mispredict = ($urandom_range(0, 7) == 0);
      e_mdu_start  = ($urandom_range(0, 5) == 0) || (m_mdu_busy && ($urandom_range(0, 3) != 0));
      mdu_done     = ($urandom_range(0, 2) == 0);
      cnt_clr      = ($urandom_range(0, 29) == 0);
      #1;
      exp_o = model_out();
      tests++;
      if (dut_out() !== exp_o) begin
        fails++;
        $display("FAIL rnd_out cyc%0d: got %b want %b", cyc, dut_out(), exp_o);
      end
      tests++;
      if (state_o !== model_state()) begin
        fails++;
        $display("FAIL rnd_state cyc%0d: got %0d want %0d", cyc, state_o, model_state());
      end
      tick();
      tests++;
      if (stall_cnt !== CW'(m_stall) || redirect_cnt !== CW'(m_redir)) begin
        fails++;
        $display("FAIL rnd_cnt cyc%0d: stall %0d/%0d redir %0d/%0d (got/want)", cyc, stall_cnt, m_stall, redirect_cnt, m_redir);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0();
    test_mdu();
    test_mispredict();
    test_mdu_mispredict();
    test_counters();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
